// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO register map, IO decode field and status bits.
package mem_io_pkg;

    localparam logic [31:0] IO_UART   = 32'h0003_0000;
    localparam logic [31:0] IO_STATUS = 32'h0003_0004;
    localparam logic [31:0] IO_CYCLE  = 32'h0003_0008;

    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_OVERFLOW = 2;

    typedef enum logic [1:0] {
        REG_UART,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } io_reg_t;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with power-of-two depth; simultaneous push/pop keeps the count, and a pop from empty is ignored.
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally at the power-of-two boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus UART-style IO window behind the core's memory port.
// Optional MEM_IO_CYCLE_COUNTER_EN adds a cycle counter readable at 0x30008-0x3000B.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int    RAM_ADDR_W = 17,
    parameter int    TX_DEPTH   = 8,
    parameter int    RX_DEPTH   = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_end
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_HIGH = (TX_AW + 1)'(TX_DEPTH - 2);

    logic [7:0] ram [2**RAM_ADDR_W];

    logic                  is_io;
    logic                  bus_rd;
    logic                  bus_wr;
    logic                  uart_wr;
    logic                  uart_rd;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_empty;
    logic                  tx_full;
    logic [7:0]            tx_head;
    logic [TX_AW:0]        tx_count;
    logic                  tx_overflow;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_empty;
    logic                  rx_full;
    logic [7:0]            rx_head;
    logic [RX_AW:0]        rx_count;
    logic [7:0]            status;
    logic [7:0]            io_rdata;
    logic [RAM_ADDR_W-1:0] ram_addr;

    // address 0 with a read is the initiator's idle pattern
    assign is_io    = is_io_addr(mem_addr);
    assign bus_rd   = rdy && !mem_wr && (mem_addr != '0);
    assign bus_wr   = rdy && mem_wr;
    assign ram_addr = mem_addr[RAM_ADDR_W-1:0];
    assign uart_wr  = bus_wr && (mem_addr == IO_UART);
    assign uart_rd  = bus_rd && (mem_addr == IO_UART);

    assign tx_push  = uart_wr && !tx_full;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_head;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = uart_rd && !rx_empty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_dout),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cyc_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (rdy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus_rd && (mem_addr == IO_CYCLE)) begin
            cyc_snap <= cyc_cnt;
        end
    end
`endif

    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = (rx_count != '0);
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_OVERFLOW] = tx_overflow;
    end

    always_comb begin
        io_rdata = '0;
        case (mem_addr)
            IO_UART:            io_rdata = rx_empty ? 8'h00 : rx_head;
            IO_STATUS:          io_rdata = status;
`ifdef MEM_IO_CYCLE_COUNTER_EN
            IO_CYCLE:           io_rdata = cyc_cnt[7:0];
            IO_CYCLE + 32'd1:   io_rdata = cyc_snap[15:8];
            IO_CYCLE + 32'd2:   io_rdata = cyc_snap[23:16];
            IO_CYCLE + 32'd3:   io_rdata = cyc_snap[31:24];
`endif
            default:            io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus_wr && !is_io) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // read port: one-cycle registered latency, holds across writes and rdy low
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_din <= '0;
        end else if (bus_rd) begin
            mem_din <= is_io ? io_rdata : ram[ram_addr];
        end
    end

    // near-full flag lags the count by a cycle; two entries of headroom absorb that
    always_ff @(posedge clk) begin
        if (rst) begin
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            sim_end        <= 1'b0;
        end else begin
            io_buffer_full <= (tx_count >= TX_HIGH);
            if (uart_wr && tx_full) begin
                tx_overflow <= 1'b1;
            end
            if (bus_wr && (mem_addr == IO_STATUS)) begin
                sim_end <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder against a queue-based behavioural model.
module tb_mem_io_responder;

    localparam int TXD = 8;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_end;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ram_m [int];
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic        ovf_m;
    logic        end_m;
    logic        bfull_m;
    logic [7:0]  din_m;
    logic [31:0] cyc_m;
    logic [31:0] snap_m;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_addr       (mem_addr),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sim_end        (sim_end)
    );

    // Applies one bus cycle and advances the model by the spec's rules, using pre-edge state.
    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
        int txn;
        int rxn;
        logic io;
        rdy = r; mem_addr = a; mem_wr = w; mem_dout = d;
        txn = tx_q.size();
        rxn = rx_q.size();
        io  = (a[17:16] == 2'b11);
        if (r && !w && a != 0) begin
            if (!io) din_m = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
            else if (a == 32'h30000) din_m = (rxn > 0) ? rx_q.pop_front() : 8'h00;
            else if (a == 32'h30004) din_m = {5'b0, ovf_m, txn == TXD, rxn != 0};
`ifdef MEM_IO_CYCLE_COUNTER_EN
            else if (a == 32'h30008) begin din_m = cyc_m[7:0]; snap_m = cyc_m; end
            else if (a == 32'h30009) din_m = snap_m[15:8];
            else if (a == 32'h3000A) din_m = snap_m[23:16];
            else if (a == 32'h3000B) din_m = snap_m[31:24];
`endif
            else din_m = 8'h00;
        end
        if (rx_valid && rxn < RXD) rx_q.push_back(rx_data);
        if (tx_ready && txn > 0) void'(tx_q.pop_front());
        if (r && w && a == 32'h30000) begin
            if (txn == TXD) ovf_m = 1'b1;
            else tx_q.push_back(d);
        end
        if (r && w && !io) ram_m[int'(a[16:0])] = d;
        if (r && w && a == 32'h30004) end_m = 1'b1;
        bfull_m = (txn >= TXD - 2);
        if (r) cyc_m = cyc_m + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; mem_addr = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete(); rx_q.delete();
        ovf_m = 1'b0; end_m = 1'b0; bfull_m = 1'b0; din_m = 8'h00; cyc_m = 0; snap_m = 0;
    endtask

    task automatic test_reset();
        rx_valid = 1'b1; rx_data = 8'h77;
        rst = 1'b1;
        @(posedge clk); #1;
        do_reset();
        n_tests++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
        n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_bfull got=%b exp=0", io_buffer_full); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        n_tests++; if (sim_end !== 1'b0) begin n_fail++; $display("FAIL reset_sim_end got=%b exp=0", sim_end); end
    endtask

    task automatic test_ram();
        logic [31:0] addrs [8];
        step(1'b1, 32'h100, 1'b1, 8'hA5);
        step(1'b1, 32'h100, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_a5 got=%h exp=a5", mem_din); end
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 32'h400 + 32'(i * 37);
            step(1'b1, addrs[i], 1'b1, 8'($urandom));
        end
        // back-to-back reads, one per cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, addrs[7 - i], 1'b0, 8'h00);
            n_tests++; if (mem_din !== din_m) begin n_fail++; $display("FAIL ram_b2b addr=%h got=%h exp=%h", addrs[7 - i], mem_din, din_m); end
        end
    endtask

    task automatic test_tx_fill();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'h30000, 1'b1, 8'h41);
        n_tests++; if (dut.tx_count !== 4'd6) begin n_fail++; $display("FAIL fill_count got=%0d exp=6", dut.tx_count); end
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL fill_head got=%b/%h exp=1/41", tx_valid, tx_data); end
        n_tests++; if (io_buffer_full !== bfull_m) begin n_fail++; $display("FAIL fill_bfull_lag got=%b exp=%b", io_buffer_full, bfull_m); end
        step(1'b1, 32'h0, 1'b0, 8'h00);
        n_tests++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL fill_bfull got=%b exp=1", io_buffer_full); end
    endtask

    task automatic test_tx_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, 32'h30000, 1'b1, 8'(i));
        step(1'b1, 32'h30004, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h06) begin n_fail++; $display("FAIL ovf_status got=%h exp=06", mem_din); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", tx_valid, tx_data, 8'(i)); end
            step(1'b1, 32'h0, 1'b0, 8'h00);
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        do_reset();
        rx_valid = 1'b1; rx_data = 8'h5A;
        step(1'b1, 32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        step(1'b1, 32'h30004, 1'b0, 8'h00);
        n_tests++; if (mem_din[0] !== 1'b1) begin n_fail++; $display("FAIL rx_status1 got=%h exp bit0=1", mem_din); end
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h5A) begin n_fail++; $display("FAIL rx_pop1 got=%h exp=5a", mem_din); end
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL rx_pop2 got=%h exp=00", mem_din); end
        step(1'b1, 32'h30004, 1'b0, 8'h00);
        n_tests++; if (mem_din[0] !== 1'b0) begin n_fail++; $display("FAIL rx_status0 got=%h exp bit0=0", mem_din); end
    endtask

    task automatic test_rdy_low();
        step(1'b1, 32'h200, 1'b1, 8'h11);
        step(1'b1, 32'h200, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h11) begin n_fail++; $display("FAIL rdy_prior got=%h exp=11", mem_din); end
        step(1'b0, 32'h200, 1'b1, 8'hFF);
        step(1'b0, 32'h100, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h11) begin n_fail++; $display("FAIL rdy_hold got=%h exp=11", mem_din); end
        step(1'b0, 32'h30004, 1'b1, 8'h00);
        n_tests++; if (sim_end !== 1'b0) begin n_fail++; $display("FAIL rdy_sim_end got=%b exp=0", sim_end); end
        step(1'b1, 32'h200, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h11) begin n_fail++; $display("FAIL rdy_readback got=%h exp=11", mem_din); end
    endtask

    task automatic test_sim_end_reset();
        step(1'b1, 32'h30004, 1'b1, 8'h00);
        n_tests++; if (sim_end !== 1'b1) begin n_fail++; $display("FAIL sim_end_set got=%b exp=1", sim_end); end
        tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h33;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h30000, 1'b1, 8'(i + 8'h20));
        do_reset();
        n_tests++; if (sim_end !== 1'b0) begin n_fail++; $display("FAIL rst_sim_end got=%b exp=0", sim_end); end
        n_tests++; if (tx_valid !== 1'b0 || dut.tx_count !== 4'd0) begin n_fail++; $display("FAIL rst_tx_empty got=%b/%0d exp=0/0", tx_valid, dut.tx_count); end
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); end
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        n_tests++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL rst_rx_empty got=%h exp=00", mem_din); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        logic        r;
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 32'(i), 1'b1, 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 7) != 0);
            tx_ready = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            w = 1'b0;
            case ($urandom_range(0, 9))
                0:       a = 32'h0;
                1, 2:    a = 32'($urandom_range(1, 63));
                3:       begin a = 32'($urandom_range(0, 63)); w = 1'b1; end
                4, 5:    begin a = 32'h30000; w = 1'b1; end
                6:       a = 32'h30000;
                7:       a = 32'h30004;
                8:       begin a = 32'h3000C; w = 1'($urandom); end
                default: begin a = 32'h30004; w = ($urandom_range(0, 9) == 0); end
            endcase
            step(r, a, w, 8'($urandom));
            n_tests++; if (mem_din !== din_m) begin n_fail++; $display("FAIL rnd_mem_din cyc=%0d got=%h exp=%h", i, mem_din, din_m); end
            n_tests++; if (tx_valid !== (tx_q.size() != 0)) begin n_fail++; $display("FAIL rnd_tx_valid cyc=%0d got=%b exp=%b", i, tx_valid, tx_q.size() != 0); end
            n_tests++; if (tx_data !== ((tx_q.size() != 0) ? tx_q[0] : 8'h00)) begin n_fail++; $display("FAIL rnd_tx_data cyc=%0d got=%h", i, tx_data); end
            n_tests++; if (rx_ready !== (rx_q.size() < RXD)) begin n_fail++; $display("FAIL rnd_rx_ready cyc=%0d got=%b exp=%b", i, rx_ready, rx_q.size() < RXD); end
            n_tests++; if (io_buffer_full !== bfull_m) begin n_fail++; $display("FAIL rnd_bfull cyc=%0d got=%b exp=%b", i, io_buffer_full, bfull_m); end
            n_tests++; if (sim_end !== end_m) begin n_fail++; $display("FAIL rnd_sim_end cyc=%0d got=%b exp=%b", i, sim_end, end_m); end
        end
        tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

`ifdef MEM_IO_CYCLE_COUNTER_EN
    task automatic test_cycle_counter();
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 32'h0, 1'b0, 8'h00);
        step(1'b1, 32'h30008, 1'b0, 8'h00); got[7:0]   = mem_din;
        step(1'b1, 32'h30009, 1'b0, 8'h00); got[15:8]  = mem_din;
        step(1'b1, 32'h3000A, 1'b0, 8'h00); got[23:16] = mem_din;
        step(1'b1, 32'h3000B, 1'b0, 8'h00); got[31:24] = mem_din;
        n_tests++; if (got !== 32'd100) begin n_fail++; $display("FAIL cycle_snapshot got=%0d exp=100", got); end
    endtask
`endif

    initial begin
        rst = 1'b1; rdy = 1'b0; mem_addr = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_ram();
        test_tx_fill();
        test_tx_overflow();
        test_rx();
        test_rdy_low();
        test_sim_end_reset();
        test_random();
`ifdef MEM_IO_CYCLE_COUNTER_EN
        test_cycle_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
